// File: rtl/dcache_miss_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_miss_ctrl
//   Miss / write-back controller for the write-back data cache. Hits are served
//   combinationally in IDLE. A cached miss latches the request and the selected
//   way (victim buffer). A dirty victim is written back as one burst, then the
//   line is refilled critical-word-first, optionally with early restart. The
//   line is written back into the way in a one-cycle COMMIT. Uncached accesses
//   run as single-beat memory transfers.
//
// Ports
//   i_clk, i_reset        clock (rising edge), asynchronous active-high reset
//   i_cpu_*               CPU access: req, wr, size (0=B 1=H 2=W), uncached,
//                         addr, wdata (lanes aligned to addr[1:0])
//   o_cpu_rdata/data_ok   load data / one-cycle completion pulse
//   i_hit, i_dirty        lookup result for the selected way
//   i_victim_addr         line base address of the selected way
//   i_line_rdata          selected way contents
//   o_line_*              line write port (data, we, valid, dirty)
//   o_mem_*, i_mem_*      memory burst interface (request/address phase,
//                         write data phase, read data phase)
//   o_busy                controller is not idle
// -----------------------------------------------------------------------------
module dcache_miss_ctrl #(
   parameter int LINE_WORDS    = 8,
   parameter bit CWF           = 1'b1,
   parameter bit EARLY_RESTART = 1'b1
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_cpu_req,
   input  logic                     i_cpu_wr,
   input  logic [1:0]               i_cpu_size,
   input  logic                     i_cpu_uncached,
   input  logic [31:0]              i_cpu_addr,
   input  logic [31:0]              i_cpu_wdata,
   output logic [31:0]              o_cpu_rdata,
   output logic                     o_cpu_data_ok,
   input  logic                     i_hit,
   input  logic                     i_dirty,
   input  logic [31:0]              i_victim_addr,
   input  logic [32*LINE_WORDS-1:0] i_line_rdata,
   output logic [32*LINE_WORDS-1:0] o_line_wdata,
   output logic                     o_line_we,
   output logic                     o_line_valid,
   output logic                     o_line_dirty,
   output logic                     o_mem_req,
   output logic                     o_mem_wr,
   output logic [31:0]              o_mem_addr,
   output logic [7:0]               o_mem_len,
   output logic [1:0]               o_mem_size,
   output logic                     o_mem_wrap,
   input  logic                     i_mem_addr_ok,
   output logic [31:0]              o_mem_wdata,
   output logic                     o_mem_wlast,
   input  logic                     i_mem_data_ok,
   input  logic [31:0]              i_mem_rdata,
   output logic                     o_busy
);

   localparam int OW = $clog2(LINE_WORDS);
   localparam logic [OW:0] LAST_BEAT = (OW+1)'(LINE_WORDS-1);
   localparam logic [OW:0] BEAT_ONE  = (OW+1)'(1);
   localparam logic [7:0]  BURST_LEN = 8'(LINE_WORDS-1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WB_REQ   = 3'd1;
   localparam logic [2:0] S_WB_DATA  = 3'd2;
   localparam logic [2:0] S_RD_REQ   = 3'd3;
   localparam logic [2:0] S_RD_DATA  = 3'd4;
   localparam logic [2:0] S_COMMIT   = 3'd5;
   localparam logic [2:0] S_UNC_REQ  = 3'd6;
   localparam logic [2:0] S_UNC_DATA = 3'd7;

   // Byte-lane enable for a store of the given size at the given offset.
   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         2'd0:    m = 4'b0001 << off;
         2'd1:    m = off[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      return r;
   endfunction

   // Control state
   logic [2:0]  r_state;
   logic [OW:0] r_beat;

   // Latched request and line buffers (no reset needed: only read after a latch)
   logic                     r_wr;
   logic [1:0]               r_size;
   logic [31:0]              r_addr;
   logic [31:0]              r_wdata;
   logic [31:0]              r_victim_addr;
   logic [32*LINE_WORDS-1:0] r_vbuf;
   logic [32*LINE_WORDS-1:0] r_rbuf;

   logic                     w_hit_acc;
   logic                     w_accept;
   logic [OW-1:0]            w_cpu_word;
   logic [OW-1:0]            w_miss_word;
   logic [OW-1:0]            w_start_word;
   logic [OW-1:0]            w_ridx;
   logic                     w_crit;
   logic [31:0]              w_hit_word;
   logic [31:0]              w_wb_word;
   logic [31:0]              w_rbuf_word;
   logic [31:0]              w_rd_addr;
   logic [32*LINE_WORDS-1:0] w_hit_line;
   logic [32*LINE_WORDS-1:0] w_commit_line;

   assign w_hit_acc    = (r_state == S_IDLE) && i_cpu_req && !i_cpu_uncached && i_hit;
   assign w_accept     = (r_state == S_IDLE) && i_cpu_req && (i_cpu_uncached || !i_hit);
   assign w_cpu_word   = i_cpu_addr[OW+1:2];
   assign w_miss_word  = r_addr[OW+1:2];
   assign w_start_word = CWF ? w_miss_word : '0;
   // Refill slot of the current beat; wraps naturally in OW bits.
   assign w_ridx       = w_start_word + r_beat[OW-1:0];
   assign w_crit       = (w_ridx == w_miss_word);
   assign w_hit_word   = i_line_rdata[32*w_cpu_word +: 32];
   assign w_wb_word    = r_vbuf[32*r_beat[OW-1:0] +: 32];
   assign w_rbuf_word  = r_rbuf[32*w_miss_word +: 32];
   assign w_rd_addr    = CWF ? {r_addr[31:2], 2'b00} : {r_addr[31:OW+2], {(OW+2){1'b0}}};
   assign o_busy       = (r_state != S_IDLE);

   always_comb begin
      w_hit_line = i_line_rdata;
      w_hit_line[32*w_cpu_word +: 32] =
         merge_word(w_hit_word, i_cpu_wdata, byte_mask(i_cpu_size, i_cpu_addr[1:0]));
      w_commit_line = r_rbuf;
      if (r_wr)
         w_commit_line[32*w_miss_word +: 32] =
            merge_word(w_rbuf_word, r_wdata, byte_mask(r_size, r_addr[1:0]));
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_cpu_req && i_cpu_uncached) begin
                  r_state <= S_UNC_REQ;
                  r_beat  <= '0;
               end else if (i_cpu_req && !i_hit) begin
                  r_state <= i_dirty ? S_WB_REQ : S_RD_REQ;
                  r_beat  <= '0;
               end
            end
            S_WB_REQ:  if (i_mem_addr_ok) r_state <= S_WB_DATA;
            S_WB_DATA: begin
               if (i_mem_data_ok) begin
                  if (r_beat == LAST_BEAT) begin
                     r_state <= S_RD_REQ;
                     r_beat  <= '0;
                  end else begin
                     r_beat <= r_beat + BEAT_ONE;
                  end
               end
            end
            S_RD_REQ:  if (i_mem_addr_ok) r_state <= S_RD_DATA;
            S_RD_DATA: begin
               if (i_mem_data_ok) begin
                  if (r_beat == LAST_BEAT) begin
                     r_state <= S_COMMIT;
                     r_beat  <= '0;
                  end else begin
                     r_beat <= r_beat + BEAT_ONE;
                  end
               end
            end
            S_COMMIT:   r_state <= S_IDLE;
            S_UNC_REQ:  if (i_mem_addr_ok) r_state <= S_UNC_DATA;
            S_UNC_DATA: if (i_mem_data_ok) r_state <= S_IDLE;
            default:    r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_wr          <= i_cpu_wr;
         r_size        <= i_cpu_size;
         r_addr        <= i_cpu_addr;
         r_wdata       <= i_cpu_wdata;
         r_victim_addr <= i_victim_addr;
         r_vbuf        <= i_line_rdata;
      end
      if ((r_state == S_RD_DATA) && i_mem_data_ok)
         r_rbuf[32*w_ridx +: 32] <= i_mem_rdata;
   end

   always_comb begin
      o_cpu_rdata   = '0;
      o_cpu_data_ok = 1'b0;
      o_line_wdata  = '0;
      o_line_we     = 1'b0;
      o_line_valid  = 1'b0;
      o_line_dirty  = 1'b0;
      o_mem_req     = 1'b0;
      o_mem_wr      = 1'b0;
      o_mem_addr    = '0;
      o_mem_len     = '0;
      o_mem_size    = '0;
      o_mem_wrap    = 1'b0;
      o_mem_wdata   = '0;
      o_mem_wlast   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_hit_acc) begin
               o_cpu_data_ok = 1'b1;
               if (i_cpu_wr) begin
                  o_line_we    = 1'b1;
                  o_line_wdata = w_hit_line;
                  o_line_valid = 1'b1;
                  o_line_dirty = 1'b1;
               end else begin
                  o_cpu_rdata = w_hit_word;
               end
            end
         end
         S_WB_REQ, S_WB_DATA: begin
            o_mem_req  = (r_state == S_WB_REQ);
            o_mem_wr   = 1'b1;
            o_mem_addr = r_victim_addr;
            o_mem_len  = BURST_LEN;
            o_mem_size = 2'd2;
            if (r_state == S_WB_DATA) begin
               o_mem_wdata = w_wb_word;
               o_mem_wlast = (r_beat == LAST_BEAT);
            end
         end
         S_RD_REQ, S_RD_DATA: begin
            o_mem_req  = (r_state == S_RD_REQ);
            o_mem_addr = w_rd_addr;
            o_mem_len  = BURST_LEN;
            o_mem_size = 2'd2;
            o_mem_wrap = CWF;
            // Early restart: forward the missed word straight from the bus.
            if ((r_state == S_RD_DATA) && i_mem_data_ok && w_crit && !r_wr && EARLY_RESTART) begin
               o_cpu_data_ok = 1'b1;
               o_cpu_rdata   = i_mem_rdata;
            end
         end
         S_COMMIT: begin
            o_line_we    = 1'b1;
            o_line_wdata = w_commit_line;
            o_line_valid = 1'b1;
            o_line_dirty = r_wr;
            if (r_wr || !EARLY_RESTART) o_cpu_data_ok = 1'b1;
            if (!r_wr) o_cpu_rdata = w_rbuf_word;
         end
         S_UNC_REQ, S_UNC_DATA: begin
            o_mem_req   = (r_state == S_UNC_REQ);
            o_mem_wr    = r_wr;
            o_mem_addr  = r_addr;
            o_mem_size  = r_size;
            o_mem_wdata = r_wdata;
            o_mem_wlast = 1'b1;
            if ((r_state == S_UNC_DATA) && i_mem_data_ok) begin
               o_cpu_data_ok = 1'b1;
               o_cpu_rdata   = i_mem_rdata;
            end
         end
         default: ;
      endcase
   end

endmodule
